// File: rtl/iic_cfg_seq_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
package iic_cfg_seq_pkg;

    // Table word field layout: {rd_flag, register[15:0], data[7:0]}
    localparam int unsigned RD_BIT  = 24;
    localparam int unsigned REG_MSB = 23;
    localparam int unsigned REG_LSB = 8;
    localparam int unsigned CFG_W   = 25;

    localparam int unsigned IDX_W   = 9;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned RETRY_W = 2;

    localparam logic [7:0] DEV_ADDR_DEF = 8'h78;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PWRUP = 4'd1,
        S_FETCH = 4'd2,
        S_ISSUE = 4'd3,
        S_WAIT  = 4'd4,
        S_CHECK = 4'd5,
        S_GAP   = 4'd6,
        S_DONE  = 4'd7,
        S_FAIL  = 4'd8
    } seq_state_e;

    // Packed view of one table entry; member order matches the bit layout above.
    typedef struct packed {
        logic        rd;
        logic [15:0] rg;
        logic [7:0]  dt;
    } cfg_word_t;

endpackage

// File: rtl/iic_cfg_seq_if.sv
// Handshake/bus between the configuration sequencer and iic_drive.
interface iic_cfg_seq_if;

    logic        start_en;
    logic        wr_rd_flag;
    logic [7:0]  i2c_device_addr;
    logic [15:0] register;
    logic [7:0]  data_byte;
    logic        busy;
    logic        err;
    logic [7:0]  rd_data;

    modport master (
        output start_en, wr_rd_flag, i2c_device_addr, register, data_byte,
        input  busy, err, rd_data
    );

    modport slave (
        input  start_en, wr_rd_flag, i2c_device_addr, register, data_byte,
        output busy, err, rd_data
    );

endinterface

// File: rtl/iic_cfg_seq_timer.sv
// Shared cycle counter used for power-up delay, inter-transaction gap and timeout.
module iic_cfg_seq_timer
    import iic_cfg_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; saturate so a stuck state cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/iic_cfg_seq.sv
// Table-driven I2C configuration sequencer feeding iic_drive.
module iic_cfg_seq
    import iic_cfg_seq_pkg::*;
#(
    parameter int unsigned CFG_NUM     = 64,
    parameter logic [7:0]  DEV_ADDR    = DEV_ADDR_DEF,
    parameter logic [15:0] PWRUP_CYC   = 16'd800,
    parameter logic [15:0] GAP_CYC     = 16'd8,
    parameter int unsigned RETRY_MAX   = 3,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               cfg_start,
    output logic [7:0]         cfg_idx,
    input  logic [CFG_W-1:0]   cfg_word,
    iic_cfg_seq_if.master      drv,
    output logic               rd_valid,
    output logic [7:0]         rd_byte,
    output logic [15:0]        rd_reg,
    output logic               cfg_busy,
    output logic               cfg_done,
    output logic               cfg_fail,
    output logic [7:0]         fail_idx
);

    // Delay/timeout parameters are assumed >= 1; the counter starts at 0 on state entry.
    localparam logic [CNT_W-1:0] PWR_LAST = PWRUP_CYC - 16'd1;
    localparam logic [CNT_W-1:0] GAP_LAST = GAP_CYC - 16'd1;
    localparam logic [CNT_W-1:0] TMO_LAST = TIMEOUT_CYC - 16'd1;
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(CFG_NUM);

    seq_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                fetch_ph_q, fetch_ph_d;
    logic [7:0]          cfg_idx_q, cfg_idx_d;
    logic                start_en_q, start_en_d;
    logic                wr_rd_flag_q, wr_rd_flag_d;
    logic [7:0]          dev_addr_q, dev_addr_d;
    logic [15:0]         register_q, register_d;
    logic [7:0]          data_byte_q, data_byte_d;
    logic                rd_valid_q, rd_valid_d;
    logic [7:0]          rd_byte_q, rd_byte_d;
    logic [15:0]         rd_reg_q, rd_reg_d;
    logic                cfg_busy_q, cfg_busy_d;
    logic                cfg_done_q, cfg_done_d;
    logic                cfg_fail_q, cfg_fail_d;
    logic [7:0]          fail_idx_q, fail_idx_d;

    logic                cnt_clr_c;
    logic                cnt_inc_c;
    logic                attempt_bad_c;
    logic [CNT_W-1:0]    cnt_q;
    cfg_word_t           word_c;

    iic_cfg_seq_timer u_timer (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .clr   (cnt_clr_c),
        .inc   (cnt_inc_c),
        .cnt   (cnt_q)
    );

    // Next-state and output logic; a NACK or timeout funnels into the shared retry path.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        retry_d       = retry_q;
        fetch_ph_d    = 1'b0;
        start_en_d    = start_en_q;
        wr_rd_flag_d  = wr_rd_flag_q;
        dev_addr_d    = DEV_ADDR;
        register_d    = register_q;
        data_byte_d   = data_byte_q;
        rd_valid_d    = 1'b0;
        rd_byte_d     = rd_byte_q;
        rd_reg_d      = rd_reg_q;
        cfg_busy_d    = cfg_busy_q;
        cfg_done_d    = cfg_done_q;
        cfg_fail_d    = cfg_fail_q;
        fail_idx_d    = fail_idx_q;
        cnt_clr_c     = 1'b0;
        cnt_inc_c     = 1'b0;
        attempt_bad_c = 1'b0;
        word_c        = cfg_word_t'(cfg_word);

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (cfg_start) begin
                    state_d    = S_PWRUP;
                    cnt_clr_c  = 1'b1;
                    idx_d      = '0;
                    retry_d    = '0;
                    cfg_done_d = 1'b0;
                    cfg_fail_d = 1'b0;
                    cfg_busy_d = 1'b1;
                end
            end
            S_PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            S_FETCH: begin
                // First cycle lets the registered table answer cfg_idx.
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    wr_rd_flag_d = word_c.rd;
                    register_d   = word_c.rg;
                    data_byte_d  = word_c.dt;
                    state_d      = S_ISSUE;
                    cnt_clr_c    = 1'b1;
                end
            end
            S_ISSUE: begin
                if (cnt_q == TMO_LAST) begin
                    attempt_bad_c = 1'b1;
                end else begin
                    cnt_inc_c = 1'b1;
                    if (!start_en_q) begin
                        // Only request when the driver is idle (covers busy=1 out of reset).
                        if (!drv.busy) begin
                            start_en_d = 1'b1;
                        end
                    end else if (drv.busy) begin
                        start_en_d = 1'b0;
                        state_d    = S_WAIT;
                        cnt_clr_c  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!drv.busy) begin
                    state_d = S_CHECK;
                end else if (cnt_q == TMO_LAST) begin
                    attempt_bad_c = 1'b1;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            S_CHECK: begin
                if (drv.err) begin
                    attempt_bad_c = 1'b1;
                end else begin
                    if (wr_rd_flag_q) begin
                        rd_valid_d = 1'b1;
                        rd_byte_d  = drv.rd_data;
                        rd_reg_d   = register_q;
                    end
                    idx_d   = idx_q + IDX_W'(1);
                    retry_d = '0;
                    if (idx_d == IDX_END) begin
                        state_d    = S_DONE;
                        cfg_done_d = 1'b1;
                        cfg_busy_d = 1'b0;
                    end else begin
                        state_d   = S_GAP;
                        cnt_clr_c = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (attempt_bad_c) begin
            start_en_d = 1'b0;
            if (32'(retry_q) < RETRY_MAX) begin
                retry_d   = retry_q + RETRY_W'(1);
                state_d   = S_GAP;
                cnt_clr_c = 1'b1;
            end else begin
                state_d    = S_FAIL;
                fail_idx_d = idx_q[7:0];
                cfg_fail_d = 1'b1;
                cfg_busy_d = 1'b0;
            end
        end

        cfg_idx_d = idx_d[7:0];
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            retry_q      <= '0;
            fetch_ph_q   <= 1'b0;
            cfg_idx_q    <= '0;
            start_en_q   <= 1'b0;
            wr_rd_flag_q <= 1'b0;
            dev_addr_q   <= DEV_ADDR;
            register_q   <= '0;
            data_byte_q  <= '0;
            rd_valid_q   <= 1'b0;
            rd_byte_q    <= '0;
            rd_reg_q     <= '0;
            cfg_busy_q   <= 1'b0;
            cfg_done_q   <= 1'b0;
            cfg_fail_q   <= 1'b0;
            fail_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            fetch_ph_q   <= fetch_ph_d;
            cfg_idx_q    <= cfg_idx_d;
            start_en_q   <= start_en_d;
            wr_rd_flag_q <= wr_rd_flag_d;
            dev_addr_q   <= dev_addr_d;
            register_q   <= register_d;
            data_byte_q  <= data_byte_d;
            rd_valid_q   <= rd_valid_d;
            rd_byte_q    <= rd_byte_d;
            rd_reg_q     <= rd_reg_d;
            cfg_busy_q   <= cfg_busy_d;
            cfg_done_q   <= cfg_done_d;
            cfg_fail_q   <= cfg_fail_d;
            fail_idx_q   <= fail_idx_d;
        end
    end

    assign cfg_idx             = cfg_idx_q;
    assign drv.start_en        = start_en_q;
    assign drv.wr_rd_flag      = wr_rd_flag_q;
    assign drv.i2c_device_addr = dev_addr_q;
    assign drv.register        = register_q;
    assign drv.data_byte       = data_byte_q;
    assign rd_valid            = rd_valid_q;
    assign rd_byte             = rd_byte_q;
    assign rd_reg              = rd_reg_q;
    assign cfg_busy            = cfg_busy_q;
    assign cfg_done            = cfg_done_q;
    assign cfg_fail            = cfg_fail_q;
    assign fail_idx            = fail_idx_q;

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Scoreboard bench for iic_cfg_seq with an iic_drive/slave behavioural model.
module tb_iic_cfg_seq;

    localparam int unsigned N    = 6;
    localparam int unsigned PWR  = 40;
    localparam int unsigned GAP  = 5;
    localparam int unsigned RMAX = 3;
    localparam int unsigned TMO  = 300;
    localparam logic [7:0]  DEV  = 8'h78;

    typedef struct { logic rd; logic [15:0] rg; logic [7:0] dt; } txn_t;
    typedef struct { logic [15:0] rg; logic [7:0] b; } rdx_t;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [7:0]  cfg_idx;
    logic [24:0] cfg_word = '0;
    logic        rd_valid;
    logic [7:0]  rd_byte;
    logic [15:0] rd_reg;
    logic        cfg_busy, cfg_done, cfg_fail;
    logic [7:0]  fail_idx;

    iic_cfg_seq_if bus();

    iic_cfg_seq #(
        .CFG_NUM(N), .DEV_ADDR(DEV), .PWRUP_CYC(16'(PWR)), .GAP_CYC(16'(GAP)),
        .RETRY_MAX(RMAX), .TIMEOUT_CYC(16'(TMO))
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_idx(cfg_idx), .cfg_word(cfg_word), .drv(bus.master),
        .rd_valid(rd_valid), .rd_byte(rd_byte), .rd_reg(rd_reg),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_fail(cfg_fail), .fail_idx(fail_idx)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          first_start = -1;
    bit          stuck = 1'b0;
    logic [24:0] tbl [N];
    int          nack [N];
    logic [7:0]  rdv [N];
    int          seen [N];
    txn_t        exp_txn [$];
    rdx_t        exp_rd [$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Registered configuration table, one cycle of latency.
    always @(posedge clk_i) cfg_word <= (32'(cfg_idx) < N) ? tbl[cfg_idx] : 25'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // iic_drive + slave model: busy=1 in reset, random transaction length, err noise while busy.
    initial begin : drv_model
        int dur;
        int k;
        bus.busy = 1'b1; bus.err = 1'b0; bus.rd_data = 8'h00; dur = 0; k = -1;
        forever begin
            @(negedge clk_i);
            if (!rst_n) begin
                bus.busy = 1'b1; bus.err = 1'b0; dur = 0;
            end else if (stuck) begin
                bus.busy = 1'b1; dur = 0;
            end else if (!bus.busy && bus.start_en) begin
                k = -1;
                for (int i = 0; i < N; i++) if (tbl[i][23:8] == bus.register) k = i;
                bus.busy = 1'b1;
                dur = $urandom_range(4, 12);
            end else if (bus.busy) begin
                if (dur == 0) begin
                    bus.busy = 1'b0;
                end else begin
                    bus.err = 1'($urandom);
                    dur--;
                    if (dur == 0) begin
                        bus.busy = 1'b0;
                        if (k >= 0) begin
                            seen[k]++;
                            bus.err = (seen[k] <= nack[k]);
                            bus.rd_data = bus.err ? 8'($urandom) : rdv[k];
                        end else begin
                            bus.err = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops expectations on every start_en request and every rd_valid strobe.
    initial begin : monitor
        logic prev_se, prev_busy;
        int   last_fall;
        txn_t t;
        rdx_t r;
        prev_se = 1'b0; prev_busy = 1'b1; last_fall = 0;
        forever begin
            @(posedge clk_i);
            #2;
            if (prev_busy && !bus.busy) last_fall = cyc;
            if (bus.start_en && !prev_se) begin
                chk("start_while_busy", 32'(bus.busy), 32'd0);
                chk("start_gap", 32'((cyc - last_fall) >= int'(GAP)), 32'd1);
                if (first_start < 0) first_start = cyc;
                if (exp_txn.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL txn_unexpected: got reg %h, expected no transaction", bus.register);
                end else begin
                    t = exp_txn.pop_front();
                    chk("txn_rw", 32'(bus.wr_rd_flag), 32'(t.rd));
                    chk("txn_reg", 32'(bus.register), 32'(t.rg));
                    chk("txn_data", 32'(bus.data_byte), 32'(t.dt));
                    chk("txn_dev", 32'(bus.i2c_device_addr), 32'(DEV));
                end
            end
            if (rd_valid) begin
                if (exp_rd.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected: got reg %h byte %h, expected none", rd_reg, rd_byte);
                end else begin
                    r = exp_rd.pop_front();
                    chk("rd_reg", 32'(rd_reg), 32'(r.rg));
                    chk("rd_byte", 32'(rd_byte), 32'(r.b));
                end
            end
            prev_se = bus.start_en; prev_busy = bus.busy;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_start_en"}, 32'(bus.start_en), 32'd0);
        chk({tag, "_dev"}, 32'(bus.i2c_device_addr), 32'(DEV));
        chk({tag, "_bus"}, {bus.register, bus.data_byte, 7'd0, bus.wr_rd_flag}, 32'd0);
        chk({tag, "_idx"}, 32'(cfg_idx), 32'd0);
        chk({tag, "_rd"}, {rd_reg, rd_byte, 7'd0, rd_valid}, 32'd0);
        chk({tag, "_flags"}, {fail_idx, 5'd0, cfg_busy, cfg_done, cfg_fail}, 32'd0);
    endtask

    // Table with unique register addresses: upper byte = entry+1 (0x30 never occurs).
    task automatic make_table(input bit rnd_rw, input bit rnd_nack);
        for (int i = 0; i < N; i++) begin
            tbl[i]  = {rnd_rw ? 1'($urandom) : 1'b0, 8'(i + 1), 8'($urandom), 8'($urandom)};
            rdv[i]  = 8'($urandom);
            nack[i] = 0;
            if (rnd_nack) nack[i] = ($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 2);
        end
    endtask

    // Reference model: entry-level outcome from the retry rules, then run and compare.
    task automatic run_seq(input int budget, input bit reset_mid);
        bit ef;
        int efi;
        int t0;
        bit fin;
        exp_txn.delete(); exp_rd.delete();
        ef = 1'b0; efi = 0; fin = 1'b0;
        for (int i = 0; i < N; i++) seen[i] = 0;
        if (stuck) begin
            ef = 1'b1; efi = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                int att;
                att = (nack[i] > int'(RMAX)) ? int'(RMAX) + 1 : nack[i] + 1;
                for (int j = 0; j < att; j++) exp_txn.push_back('{tbl[i][24], tbl[i][23:8], tbl[i][7:0]});
                if (nack[i] > int'(RMAX)) begin ef = 1'b1; efi = i; break; end
                if (tbl[i][24]) exp_rd.push_back('{tbl[i][23:8], rdv[i]});
            end
        end
        first_start = -1;
        @(negedge clk_i); cfg_start = 1'b1;
        @(negedge clk_i); cfg_start = 1'b0; t0 = cyc;
        chk("start_accept", {30'd0, cfg_busy, cfg_done}, 32'd2);
        if (reset_mid) begin
            for (int n = 0; n < budget && exp_txn.size() > int'(N) - 2; n++) @(negedge clk_i);
            chk("reached_entry1", 32'(exp_txn.size() <= int'(N) - 2), 32'd1);
            repeat (3) @(negedge clk_i);
            #2 rst_n = 1'b0;
            #1 chk_reset("midreset");
            repeat (2) @(posedge clk_i);
            #3 rst_n = 1'b1;
            return;
        end
        for (int n = 0; n < budget; n++) begin
            @(negedge clk_i);
            cfg_start = (n == 60) && cfg_busy;
            if (!cfg_busy && (cfg_done || cfg_fail)) begin fin = 1'b1; break; end
        end
        cfg_start = 1'b0;
        chk("finished", 32'(fin), 32'd1);
        chk("done_fail", {30'd0, cfg_done, cfg_fail}, ef ? 32'd1 : 32'd2);
        if (ef) chk("fail_idx", 32'(fail_idx), 32'(efi));
        chk("txn_left", 32'(exp_txn.size()), 32'd0);
        chk("rd_left", 32'(exp_rd.size()), 32'd0);
        chk("pwrup_delay", 32'(first_start < 0 || (first_start - t0) >= int'(PWR)), 32'd1);
        if (stuck) chk("timeout_time", 32'((cyc - t0) >= int'((RMAX + 1) * TMO)), 32'd1);
    endtask

    initial begin : main
        make_table(1'b0, 1'b0);
        repeat (3) @(posedge clk_i);
        #2 chk_reset("reset");
        #1 rst_n = 1'b1;

        // All writes ACKed
        make_table(1'b0, 1'b0);
        run_seq(5000, 1'b0);

        // Single read at entry 1
        make_table(1'b0, 1'b0);
        tbl[1] = {1'b1, 16'h300A, 8'h00};
        rdv[1] = 8'h56;
        run_seq(5000, 1'b0);

        // Entry 1 NACKed twice then ACKed
        make_table(1'b1, 1'b0);
        nack[1] = 2;
        run_seq(5000, 1'b0);

        // Entry 2 always NACKed
        make_table(1'b1, 1'b0);
        nack[2] = 99;
        run_seq(5000, 1'b0);

        // Driver stuck busy: timeouts exhaust the retries on entry 0
        stuck = 1'b1;
        run_seq(5000, 1'b0);
        stuck = 1'b0;

        // Reset during WAIT of entry 1, then a clean restart
        make_table(1'b1, 1'b0);
        run_seq(5000, 1'b1);
        run_seq(5000, 1'b0);

        // Random tables and NACK patterns
        for (int r = 0; r < 6; r++) begin
            make_table(1'b1, 1'b1);
            run_seq(5000, 1'b0);
        end

        repeat (5) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
